// File: rtl/text_memory_loader.sv
// Text memory loader: turns a host byte stream (length, little-endian words,
// XOR checksum) into text memory writes and holds the core while loading.
module text_memory_loader #(
  parameter logic [31:0] TEXT_BEGIN      = 32'h0040_0000,
  parameter logic [31:0] TEXT_END        = 32'h0040_FFFF,
  parameter int unsigned WORD_ADDR_WIDTH = 14
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load_request,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  output logic                       mem_wren,
  output logic [WORD_ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]                mem_data,
  output logic                       core_hold,
  output logic                       load_done,
  output logic                       load_error
);

  localparam logic [31:0] MAX_WORDS = (TEXT_END - TEXT_BEGIN + 32'd1) >> 2;
  localparam logic [WORD_ADDR_WIDTH-1:0] BASE_WORD = TEXT_BEGIN[WORD_ADDR_WIDTH+1:2];

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                     state, state_n;
  logic [1:0]                 byte_cnt, byte_cnt_n;
  logic [31:0]                length, length_n;
  logic [31:0]                word_index, word_index_n;
  logic [31:0]                word_buf, word_buf_n;
  logic [7:0]                 checksum, checksum_n;
  logic [WORD_ADDR_WIDTH-1:0] mem_address_n;
  logic [31:0]                mem_data_n;
  logic                       byte_ready_n, mem_wren_n, core_hold_n;
  logic                       load_done_n, load_error_n;

  logic        accept_c;
  logic [31:0] len_full_c;
  logic [31:0] word_full_c;
  logic [31:0] index_inc_c;

  assign accept_c    = byte_valid && byte_ready;
  assign len_full_c  = {byte_data, length[31:8]};
  assign word_full_c = {byte_data, word_buf[31:8]};
  assign index_inc_c = word_index + 32'd1;

  // State, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      byte_cnt    <= 2'd0;
      length      <= 32'd0;
      word_index  <= 32'd0;
      word_buf    <= 32'd0;
      checksum    <= 8'd0;
      mem_address <= '0;
      mem_data    <= 32'd0;
      byte_ready  <= 1'b0;
      mem_wren    <= 1'b0;
      core_hold   <= 1'b0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      state       <= state_n;
      byte_cnt    <= byte_cnt_n;
      length      <= length_n;
      word_index  <= word_index_n;
      word_buf    <= word_buf_n;
      checksum    <= checksum_n;
      mem_address <= mem_address_n;
      mem_data    <= mem_data_n;
      byte_ready  <= byte_ready_n;
      mem_wren    <= mem_wren_n;
      core_hold   <= core_hold_n;
      load_done   <= load_done_n;
      load_error  <= load_error_n;
    end
  end

  // Next-state, datapath updates and next output values
  always_comb begin
    state_n       = state;
    byte_cnt_n    = byte_cnt;
    length_n      = length;
    word_index_n  = word_index;
    word_buf_n    = word_buf;
    checksum_n    = checksum;
    mem_address_n = mem_address;
    mem_data_n    = mem_data;

    case (state)
      S_IDLE, S_ERROR: begin
        if (load_request) begin
          state_n      = S_LEN;
          byte_cnt_n   = 2'd0;
          length_n     = 32'd0;
          word_index_n = 32'd0;
          word_buf_n   = 32'd0;
          checksum_n   = 8'd0;
        end
      end
      S_LEN: begin
        if (accept_c) begin
          length_n   = len_full_c;
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            if (len_full_c > MAX_WORDS)   state_n = S_ERROR;
            else if (len_full_c == 32'd0) state_n = S_CHECK;
            else                          state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept_c) begin
          word_buf_n = word_full_c;
          checksum_n = checksum ^ byte_data;
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state_n       = S_WRITE;
            mem_address_n = BASE_WORD + word_index[WORD_ADDR_WIDTH-1:0];
            mem_data_n    = word_full_c;
          end
        end
      end
      S_WRITE: begin
        word_index_n = index_inc_c;
        state_n      = (index_inc_c == length) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (accept_c) begin
          state_n = (byte_data == checksum) ? S_DONE : S_ERROR;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    byte_ready_n = (state_n == S_LEN) || (state_n == S_DATA) || (state_n == S_CHECK);
    mem_wren_n   = (state_n == S_WRITE);
    core_hold_n  = (state_n != S_IDLE);
    load_done_n  = (state_n == S_DONE);
    load_error_n = (state_n == S_ERROR);
  end

endmodule

// File: tb/tb_text_memory_loader.sv
// Scoreboard bench for text_memory_loader: expected writes are queued as
// bytes are driven and popped when mem_wren is observed.
module tb_text_memory_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_request;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_wren;
  logic [13:0] mem_address;
  logic [31:0] mem_data;
  logic        core_hold;
  logic        load_done;
  logic        load_error;

  int errors = 0;
  int checks = 0;
  int wren_count = 0;
  int done_count = 0;

  logic [45:0] exp_q[$];
  logic [31:0] img [0:7];

  text_memory_loader dut (
    .clock        (clock),
    .reset        (reset),
    .load_request (load_request),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .mem_wren     (mem_wren),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_error   (load_error)
  );

  always #5 clock = ~clock;

  // Write monitor: every mem_wren pulse must match the head of the scoreboard
  always @(negedge clock) begin
    if (load_done) done_count++;
    if (mem_wren) begin
      logic [45:0] e;
      wren_count++;
      checks++;
      if (byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_ready: byte_ready=%b during write, required 0", byte_ready);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: addr=%0h data=%08h, no write expected", mem_address, mem_data);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({mem_address, mem_data} !== e) begin
          errors++;
          $display("FAIL write_data: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   mem_address, mem_data, e[45:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_load();
    load_request = 1'b1;
    tick();
    load_request = 1'b0;
  endtask

  // Present one byte (after an optional idle gap) and hold it until accepted
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int waited = 0;
    if (max_gap > 0) begin
      repeat ($urandom_range(max_gap, 0)) tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clock);
    while (!byte_ready && waited < 50) begin
      waited++;
      @(negedge clock);
    end
    if (!byte_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: byte %02h never accepted", b);
    end
    @(posedge clock);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_length(input logic [31:0] n, input int max_gap);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], max_gap);
  endtask

  // Full stream from img[0..n-1]; expected writes queued as the words go out
  task automatic send_stream(input int n, input logic [7:0] cs_flip, input int max_gap);
    logic [7:0] cs = 8'h00;
    logic [31:0] w;
    send_length(32'(n), max_gap);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      exp_q.push_back({14'(i), w});
      for (int k = 0; k < 4; k++) begin
        cs ^= w[8*k +: 8];
        send_byte(w[8*k +: 8], max_gap);
      end
    end
    send_byte(cs ^ cs_flip, max_gap);
  endtask

  // After the checksum byte: DONE for one cycle, then IDLE with core released
  task automatic expect_success(input string name, input int wren_before, input int n);
    @(negedge clock);
    checks++;
    if (load_done !== 1'b1 || core_hold !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: load_done=%b core_hold=%b, required 1 1", name, load_done, core_hold);
    end
    tick();
    @(negedge clock);
    checks++;
    if (load_done !== 1'b0 || core_hold !== 1'b0 || load_error !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: done=%b hold=%b err=%b ready=%b, required 0 0 0 0",
               name, load_done, core_hold, load_error, byte_ready);
    end
    checks++;
    if (wren_count - wren_before !== n || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_writes: %0d writes with %0d pending, required %0d and 0",
               name, wren_count - wren_before, exp_q.size(), n);
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++;
    if ({byte_ready, mem_wren, core_hold, load_done, load_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000",
               {byte_ready, mem_wren, core_hold, load_done, load_error});
    end
    checks++;
    if (mem_address !== 14'd0 || mem_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: addr=%0h data=%08h, required 0 0", mem_address, mem_data);
    end
    tick();
  endtask

  task automatic test_two_word();
    int wb = wren_count;
    int db = done_count;
    img[0] = 32'h1234_5678;
    img[1] = 32'hDEAD_BEEF;
    start_load();
    @(negedge clock);
    checks++;
    if (core_hold !== 1'b1 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_hold: core_hold=%b byte_ready=%b, required 1 1", core_hold, byte_ready);
    end
    tick();
    send_stream(2, 8'h00, 0);
    expect_success("two_word", wb, 2);
    checks++;
    if (done_count - db !== 1) begin
      errors++;
      $display("FAIL two_word_done_count: %0d pulses, required 1", done_count - db);
    end
  endtask

  task automatic test_bad_checksum();
    int db = done_count;
    int wb = wren_count;
    start_load();
    send_stream(2, 8'h01, 0);
    repeat (3) tick();
    @(negedge clock);
    checks++;
    if (load_error !== 1'b1 || core_hold !== 1'b1 || byte_ready !== 1'b0 || done_count !== db) begin
      errors++;
      $display("FAIL bad_cs_state: err=%b hold=%b ready=%b done_pulses=%0d, required 1 1 0 0",
               load_error, core_hold, byte_ready, done_count - db);
    end
    checks++;
    if (wren_count - wb !== 2) begin
      errors++;
      $display("FAIL bad_cs_writes: %0d writes, required 2", wren_count - wb);
    end
    tick();
    start_load();
    @(negedge clock);
    checks++;
    if (load_error !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_cs_restart: err=%b ready=%b, required 0 1", load_error, byte_ready);
    end
    tick();
    img[0] = 32'hCAFE_F00D;
    img[1] = 32'h0102_0304;
    img[2] = 32'hA5A5_5A5A;
    wb = wren_count;
    send_stream(3, 8'h00, 0);
    expect_success("recover", wb, 3);
  endtask

  task automatic test_oversize();
    int wb = wren_count;
    start_load();
    send_length(32'h0000_4001, 0);
    @(negedge clock);
    checks++;
    if (load_error !== 1'b1 || byte_ready !== 1'b0 || core_hold !== 1'b1) begin
      errors++;
      $display("FAIL oversize_error: err=%b ready=%b hold=%b, required 1 0 1",
               load_error, byte_ready, core_hold);
    end
    repeat (4) tick();
    checks++;
    if (wren_count !== wb) begin
      errors++;
      $display("FAIL oversize_writes: %0d writes, required 0", wren_count - wb);
    end
    do_reset();
  endtask

  task automatic test_zero_length();
    int wb = wren_count;
    start_load();
    send_stream(0, 8'h00, 0);
    expect_success("zero_len", wb, 0);
  endtask

  task automatic test_gapped();
    int wb = wren_count;
    img[0] = 32'h1234_5678;
    img[1] = 32'hDEAD_BEEF;
    img[2] = 32'h8000_0001;
    img[3] = 32'h7F7F_0000;
    start_load();
    send_stream(4, 8'h00, 3);
    expect_success("gapped", wb, 4);
  endtask

  task automatic test_reset_mid();
    int wb = wren_count;
    start_load();
    send_length(32'd2, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({byte_ready, mem_wren, core_hold, load_done, load_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_flags: got %b, required 00000",
               {byte_ready, mem_wren, core_hold, load_done, load_error});
    end
    checks++;
    if (mem_address !== 14'd0 || mem_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_bus: addr=%0h data=%08h, required 0 0", mem_address, mem_data);
    end
    reset = 1'b0;
    // load_request with reset high must be overridden by reset
    load_request = 1'b1;
    reset = 1'b1;
    tick();
    load_request = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (core_hold !== 1'b0 || byte_ready !== 1'b0 || wren_count !== wb) begin
      errors++;
      $display("FAIL reset_wins: hold=%b ready=%b writes=%0d, required 0 0 0",
               core_hold, byte_ready, wren_count - wb);
    end
    tick();
    img[0] = 32'h1234_5678;
    img[1] = 32'hDEAD_BEEF;
    start_load();
    send_stream(2, 8'h00, 0);
    expect_success("after_reset", wb, 2);
  endtask

  initial begin
    reset        = 1'b1;
    load_request = 1'b0;
    byte_valid   = 1'b0;
    byte_data    = 8'h00;
    test_reset();
    test_two_word();
    test_bad_checksum();
    test_oversize();
    test_zero_length();
    test_gapped();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_memory_loader.md
Name: text_memory_loader

Overview:
Write-side counterpart of the instruction-fetch path. It receives a program image as a byte stream from a host link, assembles little-endian 32-bit words and writes them into the text memory through its write port. It holds the core in reset or stall while loading, and verifies a trailing XOR checksum. It sits between the serial/debug byte source and the text memory write port, and drives the core hold line.

Parameters:
TEXT_BEGIN, 32'h00400000, byte address of the first text word.
TEXT_END, 32'h0040FFFF, last byte address of text memory (inclusive).
WORD_ADDR_WIDTH, 14, width of the text memory word address, i.e. byte address bits [15:2].

Ports:
clock  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
load_request  input  1  one-cycle pulse that starts a load session; honoured only in IDLE or ERROR.
byte_valid  input  1  byte_data holds a valid byte.
byte_data  input  8  incoming stream byte.
byte_ready  output  1  loader can accept a byte; a transfer occurs when byte_valid && byte_ready.
mem_wren  output  1  text memory write strobe.
mem_address  output  WORD_ADDR_WIDTH  text memory word address.
mem_data  output  32  word to write.
core_hold  output  1  keeps the core stalled or in reset while high.
load_done  output  1  one-cycle pulse on successful completion.
load_error  output  1  sticky error flag.

Behaviour:
- Reset: state goes to IDLE. All outputs are 0, including mem_address, mem_data, byte_ready, core_hold, load_done and load_error. Byte counter, word index, length and checksum registers are cleared.
- Reset mid-session: the session aborts immediately and no further writes occur. Words already written stay in memory.
- Stream format: 4 length bytes (word count N, little-endian), then N×4 data bytes (each word little-endian), then 1 checksum byte. The checksum is the XOR of the data bytes only; length bytes are excluded.
- MAX_WORDS = (TEXT_END - TEXT_BEGIN + 1) / 4. Default is 16384.
- Accepting a byte takes 1 cycle; maximum throughput is 1 byte per cycle.
- IDLE:
  - byte_ready is 0 and core_hold is 0.
  - On load_request: go to LEN, set core_hold=1 from the next cycle, clear the counters.
- LEN:
  - byte_ready is 1.
  - Accepted bytes fill the length register from LSB to MSB.
  - After the 4th byte: if N > MAX_WORDS, go to ERROR. If N == 0, go to CHECK. Otherwise go to DATA.
- DATA:
  - byte_ready is 1.
  - Bytes fill the word buffer from LSB to MSB, and each byte is XORed into the checksum.
  - After the 4th byte, go to WRITE.
- WRITE (exactly 1 cycle):
  - byte_ready is 0 and mem_wren is 1.
  - mem_address = TEXT_BEGIN[15:2] + word_index, truncated to WORD_ADDR_WIDTH.
  - mem_data holds the assembled word.
  - word_index increments. If the new index == N, go to CHECK; otherwise go to DATA.
  - Minimum cost is 5 cycles per word.
- mem_wren is high only in WRITE. mem_address and mem_data hold their last value at all other times.
- CHECK:
  - byte_ready is 1.
  - On an accepted byte: if it equals the running checksum, go to DONE; otherwise go to ERROR.
- DONE (1 cycle):
  - load_done is 1 and core_hold is still 1.
  - Next state is IDLE, and core_hold is 0 from that cycle.
- ERROR:
  - byte_ready is 0, load_error is 1 and core_hold is 1; the core never runs a corrupt image.
  - On load_request: clear load_error and go to LEN.
- byte_valid without byte_ready (IDLE, WRITE, ERROR, DONE): the byte is not consumed. The source must hold it.
- load_request outside IDLE or ERROR is ignored.
- If load_request and reset are high in the same cycle, reset wins.
- The word index never exceeds N-1. The upper bound of the address range is guaranteed by the N > MAX_WORDS check.

Test Plan:
- Two-word load, back-to-back bytes: 02 00 00 00, 78 56 34 12, EF BE AD DE, checksum 2A -> mem_wren pulses twice: 0x12345678 @ mem_address 0, then 0xDEADBEEF @ 1. load_done pulses once, core_hold falls the following cycle, load_error stays 0.
- Same stream with checksum 2B -> both writes occur, then load_error=1, core_hold stays 1, no load_done, byte_ready=0. A new load_request clears load_error and a correct stream then completes.
- Length bytes 01 40 00 00 (16385 words) -> ERROR right after the 4th byte, zero mem_wren pulses, load_error=1.
- Length 00 00 00 00 followed by checksum 00 -> no writes, load_done pulses, core_hold returns to 0.
- Randomly gapped byte_valid, with a byte presented during WRITE -> that byte is accepted only once byte_ready returns. Written words and checksum match the gap-free run exactly.
- Assert reset after 2 data bytes of the first word -> next cycle all outputs are 0 and state is IDLE, no write occurs. A subsequent full two-word load succeeds with correct data.
